// File: rtl/mmu_tile_sequencer_if.sv
// Operand, MMU command and result-row handshake bundle for mmu_tile_sequencer.
// The master side is the sequencer. The slave side is the MMU datapath and the result consumer.
interface mmu_tile_sequencer_if #(
    parameter int unsigned ACLEN = 8
);
    logic             op_valid_i;
    logic             op_ready_o;
    logic             mmu_cmd_valid_o;
    logic [ACLEN:0]   mmu_cmd_o;
    logic             mmu_busy_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [1:0]       res_row_o;
    logic             res_last_o;

    modport master (
        input  op_valid_i, mmu_busy_i, res_ready_i,
        output op_ready_o, mmu_cmd_valid_o, mmu_cmd_o, res_valid_o, res_row_o, res_last_o
    );

    modport slave (
        output op_valid_i, mmu_busy_i, res_ready_i,
        input  op_ready_o, mmu_cmd_valid_o, mmu_cmd_o, res_valid_o, res_row_o, res_last_o
    );
endinterface

// File: rtl/mmu_tile_sequencer.sv
// Tile sequencer for the MMU: clear, feed K operand beats, flush the skew, wait idle, drain 4 rows.
// The optional batch-norm phase and its ports are enabled by defining MMU_SEQ_BN_EN.
module mmu_tile_sequencer #(
    parameter int unsigned ACLEN     = 8,
    parameter int unsigned KLEN      = 16,
    parameter int unsigned FLUSH_LEN = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [KLEN-1:0]      k_len_i,
    input  logic                 abort_i,
`ifdef MMU_SEQ_BN_EN
    input  logic                 bn_en_i,
    input  logic                 bn_valid_i,
    output logic                 res_bn_o,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    mmu_tile_sequencer_if.master bus
);

    localparam int unsigned CW = ACLEN + 1;
    localparam int unsigned FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [CW-1:0] CMD_RESET        = CW'(0);
    localparam logic [CW-1:0] CMD_TRIGGER      = CW'(1);
    localparam logic [CW-1:0] CMD_TRIGGER_LAST = CW'(2);
    localparam logic [CW-1:0] CMD_FORWARD      = CW'(8);
`ifdef MMU_SEQ_BN_EN
    localparam logic [CW-1:0] CMD_TRIGGER_BN   = CW'(17);
`endif

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_FEED  = 4'd2,
        S_FLUSH = 4'd3,
        S_WAIT  = 4'd4,
        S_DRAIN = 4'd5,
        S_DONE  = 4'd6,
        S_ABORT = 4'd7
`ifdef MMU_SEQ_BN_EN
        ,S_BN   = 4'd8
`endif
    } state_e;

    state_e            state_q;
    logic [KLEN-1:0]   k_q;
    logic [KLEN-1:0]   beat_q;
    logic [FW-1:0]     flush_q;
    logic [1:0]        row_q;
`ifdef MMU_SEQ_BN_EN
    logic              bn_en_q;
    logic              bn_sent_q;
`endif

    logic last_beat_c;
    logic flush_last_c;

    assign last_beat_c  = (beat_q == k_q - KLEN'(1));
    assign flush_last_c = (flush_q == FW'(FLUSH_LEN - 1));

    // State and counter update; abort overrides every transition outside IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            beat_q    <= '0;
            flush_q   <= '0;
            row_q     <= '0;
`ifdef MMU_SEQ_BN_EN
            bn_en_q   <= 1'b0;
            bn_sent_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && (k_len_i != '0)) begin
                        k_q     <= k_len_i;
                        beat_q  <= '0;
                        flush_q <= '0;
                        row_q   <= '0;
`ifdef MMU_SEQ_BN_EN
                        bn_en_q   <= bn_en_i;
                        bn_sent_q <= 1'b0;
`endif
                        state_q <= S_CLR;
                    end
                end
                S_CLR: state_q <= S_FEED;
                S_FEED: begin
                    if (bus.op_valid_i) begin
                        if (last_beat_c) begin
                            beat_q  <= k_q;
                            state_q <= S_FLUSH;
                        end else begin
                            beat_q  <= beat_q + KLEN'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_last_c) state_q <= S_WAIT;
                    else              flush_q <= flush_q + FW'(1);
                end
                S_WAIT: begin
                    if (!bus.mmu_busy_i) begin
`ifdef MMU_SEQ_BN_EN
                        state_q <= bn_en_q ? S_BN : S_DRAIN;
`else
                        state_q <= S_DRAIN;
`endif
                    end
                end
`ifdef MMU_SEQ_BN_EN
                S_BN: begin
                    bn_sent_q <= 1'b1;
                    if (bn_valid_i) state_q <= S_DRAIN;
                end
`endif
                S_DRAIN: begin
                    if (bus.res_ready_i) begin
                        if (row_q == 2'd3) state_q <= S_DONE;
                        else               row_q   <= row_q + 2'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ABORT: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (abort_i && (state_q != S_IDLE)) state_q <= S_ABORT;
        end
    end

    logic            op_ready_c;
    logic            cmd_valid_c;
    logic [CW-1:0]   cmd_c;
    logic            res_valid_c;
    logic            busy_c;
    logic            done_c;
    logic            err_c;
`ifdef MMU_SEQ_BN_EN
    logic            res_bn_c;
`endif

    // Output decode from state, counters and handshake inputs; forced low during reset.
    always_comb begin
        op_ready_c  = 1'b0;
        cmd_valid_c = 1'b0;
        cmd_c       = CMD_RESET;
        res_valid_c = 1'b0;
        busy_c      = (state_q != S_IDLE);
        done_c      = 1'b0;
        err_c       = 1'b0;
`ifdef MMU_SEQ_BN_EN
        res_bn_c    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE:  err_c = start_i && (k_len_i == '0);
            S_CLR, S_ABORT: begin
                cmd_valid_c = 1'b1;
                cmd_c       = CMD_RESET;
            end
            S_FEED: begin
                op_ready_c  = bus.op_valid_i;
                cmd_valid_c = bus.op_valid_i;
                if (bus.op_valid_i) cmd_c = last_beat_c ? CMD_TRIGGER_LAST : CMD_TRIGGER;
            end
            S_FLUSH: begin
                cmd_valid_c = 1'b1;
                cmd_c       = CMD_FORWARD;
            end
`ifdef MMU_SEQ_BN_EN
            S_BN: begin
                cmd_valid_c = !bn_sent_q;
                if (!bn_sent_q) cmd_c = CMD_TRIGGER_BN;
            end
`endif
            S_DRAIN: begin
                res_valid_c = 1'b1;
`ifdef MMU_SEQ_BN_EN
                res_bn_c    = bn_en_q;
`endif
            end
            S_DONE:  done_c = 1'b1;
            default: ;
        endcase
        if (rst_i) begin
            op_ready_c  = 1'b0;
            cmd_valid_c = 1'b0;
            cmd_c       = CMD_RESET;
            res_valid_c = 1'b0;
            busy_c      = 1'b0;
            done_c      = 1'b0;
            err_c       = 1'b0;
`ifdef MMU_SEQ_BN_EN
            res_bn_c    = 1'b0;
`endif
        end
    end

    assign bus.op_ready_o      = op_ready_c;
    assign bus.mmu_cmd_valid_o = cmd_valid_c;
    assign bus.mmu_cmd_o       = cmd_c;
    assign bus.res_valid_o     = res_valid_c;
    assign bus.res_row_o       = res_valid_c ? row_q : 2'd0;
    assign bus.res_last_o      = res_valid_c && (row_q == 2'd3);
    assign busy_o              = busy_c;
    assign done_o              = done_c;
    assign err_o               = err_c;
`ifdef MMU_SEQ_BN_EN
    assign res_bn_o            = res_bn_c;
`endif

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Scoreboard bench for mmu_tile_sequencer: expected commands/rows queued with stimulus, compared to observed.
module tb_mmu_tile_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] k_len_i;
    logic        abort_i;
    logic        busy_o, done_o, err_o;
`ifdef MMU_SEQ_BN_EN
    logic        bn_en_i, bn_valid_i, res_bn_o;
`endif

    mmu_tile_sequencer_if #(.ACLEN(8)) bus ();

    mmu_tile_sequencer #(.ACLEN(8), .KLEN(16), .FLUSH_LEN(6)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .k_len_i (k_len_i),
        .abort_i (abort_i),
`ifdef MMU_SEQ_BN_EN
        .bn_en_i    (bn_en_i),
        .bn_valid_i (bn_valid_i),
        .res_bn_o   (res_bn_o),
`endif
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .bus     (bus.master)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;

    int cyc_n, done_cnt, done_cyc, err_cnt, hs_cnt, first_rv, idle_cmd_bad, bn_bad;
    int obs_cmd[$], obs_ccyc[$], obs_row[$], obs_rcyc[$], obs_hold[$];
    int exp_cmd[$], exp_ccyc[$], exp_row[$], exp_rcyc[$];
    bit busy_hist[$];

    task automatic clear_obs();
        cyc_n = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; hs_cnt = 0;
        first_rv = -1; idle_cmd_bad = 0; bn_bad = 0;
        obs_cmd.delete(); obs_ccyc.delete(); obs_row.delete(); obs_rcyc.delete(); obs_hold.delete();
        exp_cmd.delete(); exp_ccyc.delete(); exp_row.delete(); exp_rcyc.delete(); busy_hist.delete();
    endtask

    // Record DUT activity at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk_i);
        if (bus.mmu_cmd_valid_o) begin
            obs_cmd.push_back(int'(bus.mmu_cmd_o));
            obs_ccyc.push_back(cyc_n);
        end else if (bus.mmu_cmd_o != 9'd0) idle_cmd_bad++;
        if (bus.res_valid_o && bus.res_ready_i) begin
            obs_row.push_back(int'({bus.res_last_o, bus.res_row_o}));
            obs_rcyc.push_back(cyc_n);
        end
        if (bus.res_valid_o && !bus.res_ready_i) obs_hold.push_back(int'(bus.res_row_o));
        if (bus.res_valid_o && first_rv < 0) first_rv = cyc_n;
`ifdef MMU_SEQ_BN_EN
        if (bus.res_valid_o && !res_bn_o) bn_bad++;
`endif
        if (done_o) begin done_cnt++; done_cyc = cyc_n; end
        if (err_o) err_cnt++;
        if (bus.op_valid_i && bus.op_ready_o) hs_cnt++;
        busy_hist.push_back(busy_o);
        @(posedge clk_i);
        #1;
        cyc_n++;
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; k_len_i = 16'd0; abort_i = 1'b0;
        bus.op_valid_i = 1'b0; bus.mmu_busy_i = 1'b0; bus.res_ready_i = 1'b0;
`ifdef MMU_SEQ_BN_EN
        bn_en_i = 1'b0; bn_valid_i = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        idle_inputs();
        rst_i = 1'b1;
        start_i = 1'b1; bus.op_valid_i = 1'b1; bus.res_ready_i = 1'b1;
        #1;
        outs = {busy_o, done_o, err_o, bus.op_ready_o, bus.mmu_cmd_valid_o, bus.mmu_cmd_o,
                bus.res_valid_o, bus.res_row_o, bus.res_last_o};
        checks++;
        if (outs !== 18'd0) begin fails++; $display("FAIL reset_outputs: got %h, expected 0", outs); end
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_nominal(input int k, input string tag);
        clear_obs();
        exp_cmd.push_back(0); exp_ccyc.push_back(1);
        for (int b = 1; b <= k; b++) begin exp_cmd.push_back(b == k ? 2 : 1); exp_ccyc.push_back(b + 1); end
        for (int f = 0; f < 6; f++) begin exp_cmd.push_back(8); exp_ccyc.push_back(k + 2 + f); end
        for (int r = 0; r < 4; r++) begin exp_row.push_back(r | (r == 3 ? 4 : 0)); exp_rcyc.push_back(k + 9 + r); end
        for (int c = 0; c < k + 40; c++) begin
            start_i = (c == 0) || (c == 3);
            k_len_i = (c == 0) ? 16'(k) : 16'd9;
            bus.op_valid_i = 1'b1; bus.mmu_busy_i = 1'b0; bus.res_ready_i = 1'b1;
            step();
            if (done_cnt > 0) break;
        end
        idle_inputs();
        while (exp_cmd.size() > 0) begin
            int e, ec, a, ac;
            e = exp_cmd.pop_front(); ec = exp_ccyc.pop_front(); a = -1; ac = -1;
            if (obs_cmd.size() > 0) begin a = obs_cmd.pop_front(); ac = obs_ccyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL %s cmd: got %0d@c%0d, expected %0d@c%0d", tag, a, ac, e, ec); end
        end
        checks++;
        if (obs_cmd.size() !== 0) begin fails++; $display("FAIL %s extra_cmd: got %0d extra, expected 0", tag, obs_cmd.size()); end
        while (exp_row.size() > 0) begin
            int e, ec, a, ac;
            e = exp_row.pop_front(); ec = exp_rcyc.pop_front(); a = -1; ac = -1;
            if (obs_row.size() > 0) begin a = obs_row.pop_front(); ac = obs_rcyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL %s row: got {last,row}=%0d@c%0d, expected %0d@c%0d", tag, a, ac, e, ec); end
        end
        checks++;
        if (done_cyc !== k + 13 || done_cnt !== 1) begin
            fails++; $display("FAIL %s done: got %0d pulses last@c%0d, expected 1@c%0d", tag, done_cnt, done_cyc, k + 13);
        end
        checks++;
        if (hs_cnt !== k || idle_cmd_bad !== 0) begin
            fails++; $display("FAIL %s handshakes: got %0d (idle cmd nonzero %0d), expected %0d (0)", tag, hs_cnt, idle_cmd_bad, k);
        end
        checks++;
        if (busy_o !== 1'b0) begin fails++; $display("FAIL %s busy_after: got %b, expected 0", tag, busy_o); end
    endtask

    task automatic test_stall();
        int exp_c[$];
        clear_obs();
        exp_c = '{0, 1, 1, 2, 8, 8, 8, 8, 8, 8};
        foreach (exp_c[i]) exp_cmd.push_back(exp_c[i]);
        exp_ccyc.push_back(1); exp_ccyc.push_back(2); exp_ccyc.push_back(5); exp_ccyc.push_back(6);
        for (int f = 0; f < 6; f++) exp_ccyc.push_back(7 + f);
        for (int c = 0; c < 50; c++) begin
            start_i = (c == 0); k_len_i = 16'd3;
            bus.op_valid_i = !(c == 3 || c == 4); bus.mmu_busy_i = 1'b0; bus.res_ready_i = 1'b1;
            step();
            if (done_cnt > 0) break;
        end
        idle_inputs();
        while (exp_cmd.size() > 0) begin
            int e, ec, a, ac;
            e = exp_cmd.pop_front(); ec = exp_ccyc.pop_front(); a = -1; ac = -1;
            if (obs_cmd.size() > 0) begin a = obs_cmd.pop_front(); ac = obs_ccyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL stall cmd: got %0d@c%0d, expected %0d@c%0d", a, ac, e, ec); end
        end
        checks++;
        if (hs_cnt !== 3) begin fails++; $display("FAIL stall handshakes: got %0d, expected 3", hs_cnt); end
        checks++;
        if (done_cyc !== 18) begin fails++; $display("FAIL stall done: got c%0d, expected c18", done_cyc); end
    endtask

    task automatic test_wait_drain();
        clear_obs();
        exp_cmd.push_back(0); exp_ccyc.push_back(1);
        exp_cmd.push_back(2); exp_ccyc.push_back(2);
        for (int f = 0; f < 6; f++) begin exp_cmd.push_back(8); exp_ccyc.push_back(3 + f); end
        for (int r = 0; r < 4; r++) begin exp_row.push_back(r | (r == 3 ? 4 : 0)); exp_rcyc.push_back(16 + 2 * r); end
        for (int c = 0; c < 60; c++) begin
            start_i = (c == 0); k_len_i = 16'd1;
            bus.op_valid_i = 1'b1; bus.mmu_busy_i = (c >= 9 && c <= 13); bus.res_ready_i = (c % 2 == 0);
            step();
            if (done_cnt > 0) break;
        end
        idle_inputs();
        while (exp_cmd.size() > 0) begin
            int e, ec, a, ac;
            e = exp_cmd.pop_front(); ec = exp_ccyc.pop_front(); a = -1; ac = -1;
            if (obs_cmd.size() > 0) begin a = obs_cmd.pop_front(); ac = obs_ccyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL wait cmd: got %0d@c%0d, expected %0d@c%0d", a, ac, e, ec); end
        end
        checks++;
        if (first_rv !== 15) begin fails++; $display("FAIL wait drain_start: got c%0d, expected c15", first_rv); end
        while (exp_row.size() > 0) begin
            int e, ec, a, ac;
            e = exp_row.pop_front(); ec = exp_rcyc.pop_front(); a = -1; ac = -1;
            if (obs_row.size() > 0) begin a = obs_row.pop_front(); ac = obs_rcyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL drain row: got {last,row}=%0d@c%0d, expected %0d@c%0d", a, ac, e, ec); end
        end
        for (int r = 0; r < 4; r++) begin
            int h;
            h = (obs_hold.size() > 0) ? obs_hold[0] : -1;
            if (obs_hold.size() > 0) void'(obs_hold.pop_front());
            checks++;
            if (h !== r) begin fails++; $display("FAIL drain hold: got row %0d, expected %0d", h, r); end
        end
        checks++;
        if (done_cyc !== 23) begin fails++; $display("FAIL wait done: got c%0d, expected c23", done_cyc); end
    endtask

    task automatic test_abort();
        int exp_c[$];
        clear_obs();
        exp_c = '{0, 1, 1, 0};
        foreach (exp_c[i]) begin exp_cmd.push_back(exp_c[i]); exp_ccyc.push_back(i + 1); end
        for (int c = 0; c < 10; c++) begin
            start_i = (c == 0); k_len_i = 16'd8; abort_i = (c == 3);
            bus.op_valid_i = 1'b1; bus.mmu_busy_i = 1'b0; bus.res_ready_i = 1'b1;
            step();
        end
        idle_inputs();
        while (exp_cmd.size() > 0) begin
            int e, ec, a, ac;
            e = exp_cmd.pop_front(); ec = exp_ccyc.pop_front(); a = -1; ac = -1;
            if (obs_cmd.size() > 0) begin a = obs_cmd.pop_front(); ac = obs_ccyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL abort cmd: got %0d@c%0d, expected %0d@c%0d", a, ac, e, ec); end
        end
        checks++;
        if (obs_cmd.size() !== 0 || done_cnt !== 0) begin
            fails++; $display("FAIL abort quiet: got %0d extra cmds %0d done, expected 0 0", obs_cmd.size(), done_cnt);
        end
        checks++;
        if (busy_hist[4] !== 1'b1 || busy_hist[5] !== 1'b0) begin
            fails++; $display("FAIL abort busy: got c4=%b c5=%b, expected 1 0", busy_hist[4], busy_hist[5]);
        end
    endtask

    task automatic test_err();
        clear_obs();
        for (int c = 0; c < 5; c++) begin
            start_i = (c == 0); k_len_i = 16'd0;
            bus.op_valid_i = 1'b1; bus.res_ready_i = 1'b1;
            step();
        end
        idle_inputs();
        checks++;
        if (err_cnt !== 1) begin fails++; $display("FAIL err_pulse: got %0d, expected 1", err_cnt); end
        checks++;
        if (obs_cmd.size() !== 0 || busy_hist[1] !== 1'b0) begin
            fails++; $display("FAIL err_quiet: got %0d cmds busy=%b, expected 0 0", obs_cmd.size(), busy_hist[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] outs;
        clear_obs();
        for (int c = 0; c < 6; c++) begin
            start_i = (c == 0); k_len_i = 16'd2;
            bus.op_valid_i = 1'b1; bus.res_ready_i = 1'b1;
            step();
        end
        checks++;
        if (busy_o !== 1'b1 || bus.mmu_cmd_valid_o !== 1'b1) begin
            fails++; $display("FAIL midflush_pre: got busy=%b cmd_valid=%b, expected 1 1", busy_o, bus.mmu_cmd_valid_o);
        end
        rst_i = 1'b1;
        #1;
        outs = {busy_o, done_o, err_o, bus.op_ready_o, bus.mmu_cmd_valid_o, bus.mmu_cmd_o,
                bus.res_valid_o, bus.res_row_o, bus.res_last_o};
        checks++;
        if (outs !== 18'd0) begin fails++; $display("FAIL midflush_reset: got %h, expected 0", outs); end
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

`ifdef MMU_SEQ_BN_EN
    task automatic test_bn();
        clear_obs();
        exp_cmd.push_back(0); exp_ccyc.push_back(1);
        exp_cmd.push_back(2); exp_ccyc.push_back(2);
        for (int f = 0; f < 6; f++) begin exp_cmd.push_back(8); exp_ccyc.push_back(3 + f); end
        exp_cmd.push_back(17); exp_ccyc.push_back(10);
        for (int c = 0; c < 50; c++) begin
            start_i = (c == 0); k_len_i = 16'd1; bn_en_i = (c == 0); bn_valid_i = (c >= 13);
            bus.op_valid_i = 1'b1; bus.mmu_busy_i = 1'b0; bus.res_ready_i = 1'b1;
            step();
            if (done_cnt > 0) break;
        end
        idle_inputs();
        while (exp_cmd.size() > 0) begin
            int e, ec, a, ac;
            e = exp_cmd.pop_front(); ec = exp_ccyc.pop_front(); a = -1; ac = -1;
            if (obs_cmd.size() > 0) begin a = obs_cmd.pop_front(); ac = obs_ccyc.pop_front(); end
            checks++;
            if (a !== e || ac !== ec) begin fails++; $display("FAIL bn cmd: got %0d@c%0d, expected %0d@c%0d", a, ac, e, ec); end
        end
        checks++;
        if (first_rv !== 14 || bn_bad !== 0 || done_cyc !== 18) begin
            fails++; $display("FAIL bn drain: got start c%0d bn_low %0d done c%0d, expected c14 0 c18", first_rv, bn_bad, done_cyc);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_i = 1'b0;
        test_reset();
        test_nominal(4, "nominal_k4");
        test_stall();
        test_wait_drain();
        test_abort();
        test_err();
        test_reset_mid();
        test_nominal(1, "fresh_k1");
        test_nominal(3, "back_to_back_k3");
`ifdef MMU_SEQ_BN_EN
        test_bn();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
